apb_protocol_top: RTL and testbench
===================================

Name: apb_protocol_top

Overview:
- Self-contained APB subsystem: an APB master FSM driven by a simple user request interface, plus one internal APB slave (register-file memory).
- Sits as the top-level wrapper.
- User requests a read or write each time the bus becomes free.
- Block returns read data and a slave-error flag.

Parameters:
- ADDR_WIDTH, 8, width of write/read addresses and PADDR.
- DATA_WIDTH, 8, width of write/read data and PWDATA/PRDATA.
- MEM_DEPTH, 256, number of slave memory locations (2**ADDR_WIDTH).

Ports:
- PCLK  input  1  system clock; all logic on rising edge.
- PRESETn  input  1  reset, asynchronous, active-high (despite the name, 1 = reset).
- transfer  input  1  request: 1 = perform transfers back-to-back while held.
- READ_WRITE  input  1  direction: 0 = write, 1 = read; sampled in IDLE/ACCESS-complete when the next SETUP is entered.
- apb_write_paddr  input  ADDR_WIDTH  write address.
- apb_write_data  input  DATA_WIDTH  write data.
- apb_read_paddr  input  ADDR_WIDTH  read address.
- PSLVERR  output  1  slave error of the most recently completed transfer.
- apb_read_data_out  output  DATA_WIDTH  data of the most recently completed good read.

Behaviour:
- Reset (async, PRESETn=1):
  - state=IDLE; internal PSEL/PENABLE/PWRITE=0; PADDR/PWDATA=0.
  - PSLVERR=0; apb_read_data_out=0.
  - All slave memory valid bits cleared; memory contents cleared to 0.
- Master FSM states: IDLE, SETUP, ACCESS.
- IDLE:
  - PSEL=0, PENABLE=0.
  - If transfer=1, go to SETUP next edge, else stay.
- Entering SETUP (registered on that edge):
  - PWRITE = ~READ_WRITE.
  - PADDR = READ_WRITE ? apb_read_paddr : apb_write_paddr.
  - PWDATA = apb_write_data.
- SETUP: PSEL=1, PENABLE=0; unconditionally go to ACCESS.
- ACCESS: PSEL=1, PENABLE=1.
  - If PREADY=0, stay in ACCESS; PADDR/PWDATA/PWRITE held.
  - If PREADY=1, transfer completes on this edge. Then go to SETUP (relatching inputs) if transfer=1, else IDLE.
- Baseline slave: PREADY=1 always, so one transfer = 2 cycles (SETUP+ACCESS).
- Slave write on completion: mem[PADDR] <= PWDATA; valid[PADDR] <= 1; PSLVERR <= 0.
- Slave read on completion:
  - If valid[PADDR]=1: apb_read_data_out <= mem[PADDR]; PSLVERR <= 0.
  - If valid[PADDR]=0 (location never written since reset): PSLVERR <= 1; apb_read_data_out <= 0.
- PSLVERR and apb_read_data_out update only at transfer completion and hold otherwise. Writes never change apb_read_data_out.
- transfer dropped during SETUP or ACCESS: the current transfer still completes; then IDLE.
- Input address/data changes outside the SETUP-entry edge have no effect on the in-flight transfer.
- Reset mid-transfer: transfer aborted immediately, no memory update, all state per reset values.
- Addresses use the full ADDR_WIDTH; no out-of-range case when MEM_DEPTH = 2**ADDR_WIDTH.

Optional Feature:
- Macro APB_WAIT_STATE_EN.
- Defined: slave drives PREADY=0 on the first ACCESS cycle and 1 on the second, so each transfer = 3 cycles (SETUP, ACCESS-wait, ACCESS-done).
- Undefined: PREADY tied to 1, 2-cycle transfers.
- Functional results (memory, PSLVERR, read data) are identical in both builds.

Decomposition:
- Package apb_pkg: state enum (IDLE, SETUP, ACCESS), ADDR_WIDTH/DATA_WIDTH defaults.
- Sub-module apb_slave_mem:
  - Inputs: PCLK, PRESETn, PSEL, PENABLE, PWRITE, PADDR, PWDATA.
  - Outputs: PREADY, PRDATA, PSLVERR (combinational, valid during ACCESS).
  - Contains memory and valid bits.
- Master FSM and output registers live in the top.

Test Plan:
- Reset then write 8 entries back-to-back (addr i, data 2*i, i=0..7, inputs changed every 2 cycles, transfer=1) -> one completion per 2 cycles, PSLVERR stays 0, apb_read_data_out stays 0.
- After writes, read addr 0..7 back-to-back -> apb_read_data_out = 0,2,4,...,14 at successive completions; PSLVERR=0.
- Read addr 22 never written -> PSLVERR=1, apb_read_data_out=0; then a subsequent write to 22 with data 35 followed by a read of 22 -> 35, PSLVERR=0.
- Assert reset mid-ACCESS of a write to addr 5 with data 0x55 -> FSM IDLE, outputs 0; later read of addr 5 -> PSLVERR=1 (valid bits cleared).
- transfer deasserted during SETUP -> that transfer still completes, then FSM idles with PSEL=0.
- With APB_WAIT_STATE_EN: write/read addr 3 data 0x06 -> each transfer takes 3 cycles, read returns 0x06.

Source files
------------

// File: rtl/apb_pkg.sv
// apb_pkg: shared APB master state encoding and default bus widths
package apb_pkg;
  localparam int ADDR_W_DEF = 8;
  localparam int DATA_W_DEF = 8;
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_e;
endpackage

// File: rtl/apb_slave_mem.sv
// apb_slave_mem: APB register-file slave with per-location valid bits; reads of unwritten locations error.
// APB_WAIT_STATE_EN inserts one wait state per transfer.
module apb_slave_mem
  import apb_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_W_DEF,
  parameter int DATA_WIDTH = DATA_W_DEF,
  parameter int MEM_DEPTH  = 2**ADDR_WIDTH
) (
  input  logic                  PCLK,
  input  logic                  PRESETn,
  input  logic                  PSEL,
  input  logic                  PENABLE,
  input  logic                  PWRITE,
  input  logic [ADDR_WIDTH-1:0] PADDR,
  input  logic [DATA_WIDTH-1:0] PWDATA,
  output logic                  PREADY,
  output logic [DATA_WIDTH-1:0] PRDATA,
  output logic                  PSLVERR
);
  logic [DATA_WIDTH-1:0] mem_q [MEM_DEPTH];
  logic [MEM_DEPTH-1:0]  valid_q;
  logic                  wr_en;
`ifdef APB_WAIT_STATE_EN
  logic wait_q, wait_d;
  // wait_q is set only during the second ACCESS cycle
  assign wait_d = PSEL & PENABLE & ~wait_q;
  always_ff @(posedge PCLK or posedge PRESETn)
    if (PRESETn) wait_q <= 1'b0;
    else         wait_q <= wait_d;
  assign PREADY = wait_q;
`else
  assign PREADY = 1'b1;
`endif
  assign wr_en   = PSEL & PENABLE & PREADY & PWRITE;
  assign PRDATA  = mem_q[PADDR];
  assign PSLVERR = PSEL & PENABLE & ~PWRITE & ~valid_q[PADDR];
  always_ff @(posedge PCLK or posedge PRESETn)
    if (PRESETn) begin
      valid_q <= '0;
      for (int i = 0; i < MEM_DEPTH; i++) mem_q[i] <= '0;
    end else if (wr_en) begin
      mem_q[PADDR]   <= PWDATA;
      valid_q[PADDR] <= 1'b1;
    end
endmodule

// File: rtl/apb_protocol_top.sv
// apb_protocol_top: APB master FSM driven by a user request interface, wired to one internal memory slave.
// APB_WAIT_STATE_EN (in apb_slave_mem) makes each transfer take three cycles instead of two.
module apb_protocol_top
  import apb_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_W_DEF,
  parameter int DATA_WIDTH = DATA_W_DEF,
  parameter int MEM_DEPTH  = 2**ADDR_WIDTH
) (
  input  logic                  PCLK,
  input  logic                  PRESETn,
  input  logic                  transfer,
  input  logic                  READ_WRITE,
  input  logic [ADDR_WIDTH-1:0] apb_write_paddr,
  input  logic [DATA_WIDTH-1:0] apb_write_data,
  input  logic [ADDR_WIDTH-1:0] apb_read_paddr,
  output logic                  PSLVERR,
  output logic [DATA_WIDTH-1:0] apb_read_data_out
);
  state_e                state_q, state_d;
  logic                  psel, penable, pready, slv_err, done;
  logic                  pwrite_q;
  logic [ADDR_WIDTH-1:0] paddr_q;
  logic [DATA_WIDTH-1:0] pwdata_q, prdata, rdata_q;
  logic                  pslverr_q;
  assign done = (state_q == ACCESS) & pready;
  always_ff @(posedge PCLK or posedge PRESETn)
    if (PRESETn) state_q <= IDLE;
    else         state_q <= state_d;
  always_comb
    state_d = (state_q == IDLE)  ? (transfer ? SETUP : IDLE) :
              (state_q == SETUP) ? ACCESS :
              done               ? (transfer ? SETUP : IDLE) : ACCESS;
  always_comb begin
    psel    = state_q != IDLE;
    penable = state_q == ACCESS;
  end
  // request inputs are captured only on the edge that enters SETUP
  always_ff @(posedge PCLK or posedge PRESETn)
    if (PRESETn) begin
      pwrite_q  <= 1'b0;
      paddr_q   <= '0;
      pwdata_q  <= '0;
      pslverr_q <= 1'b0;
      rdata_q   <= '0;
    end else begin
      if (state_d == SETUP) begin
        pwrite_q <= ~READ_WRITE;
        paddr_q  <= READ_WRITE ? apb_read_paddr : apb_write_paddr;
        pwdata_q <= apb_write_data;
      end
      if (done) begin
        pslverr_q <= slv_err;
        if (!pwrite_q) rdata_q <= slv_err ? '0 : prdata;
      end
    end
  apb_slave_mem #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .DATA_WIDTH(DATA_WIDTH),
    .MEM_DEPTH (MEM_DEPTH)
  ) u_slave (
    .PCLK   (PCLK),
    .PRESETn(PRESETn),
    .PSEL   (psel),
    .PENABLE(penable),
    .PWRITE (pwrite_q),
    .PADDR  (paddr_q),
    .PWDATA (pwdata_q),
    .PREADY (pready),
    .PRDATA (prdata),
    .PSLVERR(slv_err)
  );
  assign PSLVERR           = pslverr_q;
  assign apb_read_data_out = rdata_q;
endmodule

// File: tb/tb_apb_protocol_top.sv
// tb_apb_protocol_top: randomized transfers checked against a memory/valid-bit reference model.
module tb_apb_protocol_top;
`ifdef APB_WAIT_STATE_EN
  localparam int NCYC = 3;
`else
  localparam int NCYC = 2;
`endif
  typedef struct {
    logic       rd;
    logic [7:0] wa, wd, ra;
  } op_t;
  logic       clk = 1'b0, rst = 1'b1, transfer = 1'b0, rw = 1'b0;
  logic [7:0] wa = '0, wd = '0, ra = '0, rd_out;
  logic       err;
  logic [7:0] mem_m [256];
  logic       val_m [256];
  logic       exp_err;
  logic [7:0] exp_rd;
  op_t        ops[$];
  int         n_chk = 0, n_pass = 0;
  apb_protocol_top dut (
    .PCLK             (clk),
    .PRESETn          (rst),
    .transfer         (transfer),
    .READ_WRITE       (rw),
    .apb_write_paddr  (wa),
    .apb_write_data   (wd),
    .apb_read_paddr   (ra),
    .PSLVERR          (err),
    .apb_read_data_out(rd_out)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got %0h expected %0h", tag, got, exp);
  endtask
  task automatic model_reset();
    for (int i = 0; i < 256; i++) begin
      mem_m[i] = '0;
      val_m[i] = 1'b0;
    end
    exp_err = 1'b0;
    exp_rd  = '0;
  endtask
  task automatic model(input op_t o);
    if (!o.rd) begin
      mem_m[o.wa] = o.wd;
      val_m[o.wa] = 1'b1;
      exp_err     = 1'b0;
    end else if (val_m[o.ra]) begin
      exp_rd  = mem_m[o.ra];
      exp_err = 1'b0;
    end else begin
      exp_rd  = '0;
      exp_err = 1'b1;
    end
  endtask
  task automatic apply(input op_t o);
    rw = o.rd;
    wa = o.wa;
    wd = o.wd;
    ra = o.ra;
  endtask
  function automatic op_t mk(input logic r, input logic [7:0] a, input logic [7:0] d);
    op_t o;
    o.rd = r;
    o.wa = r ? 8'($urandom) : a;
    o.wd = d;
    o.ra = r ? a : 8'($urandom);
    return o;
  endfunction
  // runs ops back-to-back from IDLE; transfer drops during the last SETUP
  task automatic run_ops();
    transfer = 1'b1;
    apply(ops[0]);
    @(posedge clk); #1;
    for (int k = 0; k < ops.size(); k++) begin
      if (k + 1 < ops.size()) apply(ops[k+1]);
      else begin
        transfer = 1'b0;
        apply(mk(1'($urandom), 8'($urandom), 8'($urandom)));
      end
      for (int c = 1; c < NCYC; c++) begin
        @(posedge clk); #1;
        check("hold_err", err, exp_err);
        check("hold_rd", rd_out, exp_rd);
      end
      @(posedge clk); #1;
      model(ops[k]);
      check("err", err, exp_err);
      check("rd", rd_out, exp_rd);
    end
    check("idle_psel", dut.psel, 1'b0);
    ops.delete();
  endtask
  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_err", err, 1'b0);
    check("rst_rd", rd_out, 8'h00);
    check("rst_psel", dut.psel, 1'b0);
    rst = 1'b0;
    @(posedge clk); #1;
    for (int i = 0; i < 8; i++) ops.push_back(mk(1'b0, 8'(i), 8'(2 * i)));
    run_ops();
    for (int i = 0; i < 8; i++) ops.push_back(mk(1'b1, 8'(i), 8'($urandom)));
    run_ops();
    ops.push_back(mk(1'b1, 8'd22, 8'h00));
    ops.push_back(mk(1'b0, 8'd22, 8'd35));
    ops.push_back(mk(1'b1, 8'd22, 8'h00));
    run_ops();
    check("rd22", rd_out, 8'd35);
    // reset asserted during the ACCESS phase of a write to 5
    transfer = 1'b1;
    apply(mk(1'b0, 8'd5, 8'h55));
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    model_reset();
    check("mid_rst_err", err, 1'b0);
    check("mid_rst_rd", rd_out, 8'h00);
    check("mid_rst_psel", dut.psel, 1'b0);
    transfer = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    ops.push_back(mk(1'b1, 8'd5, 8'h00));
    run_ops();
    check("rd5_err", err, 1'b1);
    for (int b = 0; b < 6; b++) begin
      int n = $urandom_range(1, 6);
      for (int i = 0; i < n; i++)
        ops.push_back(mk(1'($urandom), 8'($urandom_range(0, 15)), 8'($urandom)));
      run_ops();
      repeat ($urandom_range(0, 3)) begin
        apply(mk(1'($urandom), 8'($urandom), 8'($urandom)));
        @(posedge clk); #1;
        check("gap_err", err, exp_err);
        check("gap_rd", rd_out, exp_rd);
      end
    end
    ops.push_back(mk(1'b0, 8'd3, 8'h06));
    ops.push_back(mk(1'b1, 8'd3, 8'h00));
    run_ops();
    check("rd3", rd_out, 8'h06);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
